// File: rtl/if_pkg.sv
// Shared types and constants for the DLX instruction-fetch front end.
package if_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [0:INST_W-1] inst;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Prefetch buffer: synchronous FIFO of fetch entries with a dominant flush.
module if_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic full;
    logic do_push;
    logic do_pop;

    assign empty = (count == '0);
    assign full = (count == (PTR_W+1)'(DEPTH));
    assign do_pop = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10: count <= count + (PTR_W+1)'(1);
                2'b01: count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/if_prefetch_stage.sv
// DLX fetch front end: issues word fetches, buffers responses, feeds decode.
// Optional IF_PERF_CNT_EN adds perf_fetched/perf_dropped counters.
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [0:31] imem_rdata,
    input  logic        stall,
    input  logic        branch,
    input  logic [31:0] branch_pc,
    output logic        valid_id,
    output logic [0:31] inst_id,
    output logic [31:0] pc_id,
    output logic [31:0] pc_plus_four_id
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);

    localparam int CNT_W  = $clog2(MAX_OUT + 1);
    localparam int FCNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W  = FCNT_W + 1;

    logic [31:0]      fetch_pc;
    logic [31:0]      rsp_pc;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] drop_cnt;

    logic [FCNT_W-1:0] fifo_count;
    logic              fifo_empty;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    logic [SUM_W-1:0] occupancy;
    logic grant;
    logic rsp;
    logic discard;
    logic push;
    logic pop;

    // Requests still expected to land in the FIFO count against its free space.
    assign occupancy = SUM_W'(out_cnt) - SUM_W'(drop_cnt) + SUM_W'(fifo_count);

    assign imem_req = !reset && !branch
                      && (out_cnt < CNT_W'(MAX_OUT))
                      && (occupancy < SUM_W'(DEPTH));
    assign imem_addr = fetch_pc;

    assign grant   = imem_req && imem_gnt;
    assign rsp     = imem_rvalid && !reset && (out_cnt != '0);
    assign discard = rsp && (branch || (drop_cnt != '0));
    assign push    = rsp && !discard;
    assign pop     = valid_id && !stall && !branch;

    assign push_entry.pc   = rsp_pc;
    assign push_entry.inst = imem_rdata;

    if_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (branch),
        .wdata (push_entry),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign valid_id        = !fifo_empty;
    assign inst_id         = head.inst;
    assign pc_id           = head.pc;
    assign pc_plus_four_id = next_pc(head.pc);

    // On a redirect every request still outstanding after this cycle is stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else if (branch) begin
            fetch_pc <= branch_pc;
            rsp_pc   <= branch_pc;
            out_cnt  <= out_cnt - CNT_W'(rsp);
            drop_cnt <= out_cnt - CNT_W'(rsp);
        end else begin
            if (grant) begin
                fetch_pc <= next_pc(fetch_pc);
            end
            if (push) begin
                rsp_pc <= next_pc(rsp_pc);
            end
            case ({grant, rsp})
                2'b10: out_cnt <= out_cnt + CNT_W'(1);
                2'b01: out_cnt <= out_cnt - CNT_W'(1);
                default: ;
            endcase
            if (rsp && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (discard) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed and randomized checks of the fetch front end against an in-order memory model.
module tb_if_prefetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [0:31] imem_rdata;
    logic        stall;
    logic        branch;
    logic [31:0] branch_pc;
    logic        valid_id;
    logic [0:31] inst_id;
    logic [31:0] pc_id;
    logic [31:0] pc_plus_four_id;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;
    int pops = 0;
    bit gnt_rand = 1'b0;
    bit rsp_rand = 1'b0;
    logic [31:0] exp_pc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t q[$];

    if_prefetch_stage #(
        .DEPTH(4),
        .MAX_OUT(2),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .branch          (branch),
        .branch_pc       (branch_pc),
        .valid_id        (valid_id),
        .inst_id         (inst_id),
        .pc_id           (pc_id),
        .pc_plus_four_id (pc_plus_four_id)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_dropped    (perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic b, input logic [31:0] bpc);
        @(negedge clk);
        reset = r;
        stall = s;
        branch = b;
        branch_pc = bpc;
        #1;
    endtask

    // Memory: in-order responses no earlier than lat cycles after the grant.
    initial begin
        req_t r;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (q.size() > 0 && q[0].due <= cyc && (!rsp_rand || $urandom_range(0, 2) != 0)) begin
                imem_rvalid = 1'b1;
                imem_rdata = inst_of(q[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata = '0;
            end
            #3;
            if (reset) begin
                q.delete();
            end else begin
                if (imem_rvalid) begin
                    void'(q.pop_front());
                end
                if (imem_req && imem_gnt) begin
                    r.addr = imem_addr;
                    r.due = cyc + lat;
                    q.push_back(r);
                end
            end
            cyc++;
        end
    end

    // Decode-side monitor: every consumed instruction continues the +4 stream.
    initial begin
        exp_pc = RESET_PC;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                exp_pc = RESET_PC;
            end else if (branch) begin
                exp_pc = branch_pc;
            end else if (valid_id && !stall) begin
                checkOutput("stream_pc", pc_id, exp_pc);
                checkOutput("stream_inst", inst_id, inst_of(pc_id));
                checkOutput("stream_pc4", pc_plus_four_id, pc_id + 32'd4);
                exp_pc = pc_id + 32'd4;
                pops++;
            end
        end
    end

    initial begin
        int pops_before;
        logic s;
        logic b;
        logic [31:0] bpc;
        reset = 1'b1;
        stall = 1'b0;
        branch = 1'b0;
        branch_pc = '0;

        $display("[TB] sequential fetch");
        lat = 1;
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("reset_valid", valid_id, 32'd0);
        checkOutput("reset_req", imem_req, 32'd0);
`ifdef IF_PERF_CNT_EN
        checkOutput("reset_perf_fetched", perf_fetched, 32'd0);
        checkOutput("reset_perf_dropped", perf_dropped, 32'd0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("seq_req0", imem_req, 32'd1);
        checkOutput("seq_addr0", imem_addr, 32'h0);
        checkOutput("seq_valid0", valid_id, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("seq_addr1", imem_addr, 32'h4);
        checkOutput("seq_valid1", valid_id, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("seq_addr2", imem_addr, 32'h8);
        checkOutput("seq_valid2", valid_id, 32'd1);
        checkOutput("seq_pc2", pc_id, 32'h0);
        checkOutput("seq_pc4_2", pc_plus_four_id, 32'h4);
        checkOutput("seq_inst2", inst_id, inst_of(32'h0));
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("seq_pc3", pc_id, 32'h4);

        $display("[TB] stall fill and drain");
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            if (i == 5) begin
                checkOutput("full_req", imem_req, 32'd0);
                checkOutput("full_valid", valid_id, 32'd1);
                checkOutput("full_pc", pc_id, 32'h0);
            end
        end
        checkOutput("full_req_hold", imem_req, 32'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput("drain_valid", valid_id, 32'd1);
            checkOutput("drain_pc", pc_id, 32'(i * 4));
        end

        $display("[TB] branch with two in flight");
        lat = 3;
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("br_addr0", imem_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("br_addr1", imem_addr, 32'h4);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
        checkOutput("br_req_branch", imem_req, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("br_req_full", imem_req, 32'd0);
        checkOutput("br_valid3", valid_id, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("br_req_target", imem_req, 32'd1);
        checkOutput("br_addr_target", imem_addr, 32'h100);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
`ifdef IF_PERF_CNT_EN
        checkOutput("br_perf_dropped", perf_dropped, 32'd2);
`endif
        checkOutput("br_valid5", valid_id, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("br_valid7", valid_id, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("br_valid8", valid_id, 32'd1);
        checkOutput("br_pc8", pc_id, 32'h100);
        checkOutput("br_pc4_8", pc_plus_four_id, 32'h104);

        $display("[TB] branch coinciding with a response");
        lat = 2;
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("brr_addr0", imem_addr, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("brr_addr1", imem_addr, 32'h4);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("brr_req2", imem_req, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("brr_addr3", imem_addr, 32'h8);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("brr_addr4", imem_addr, 32'hC);
        checkOutput("brr_pc4", pc_id, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h200);
        checkOutput("brr_rvalid_in_branch", imem_rvalid, 32'd1);
        checkOutput("brr_valid_pre", valid_id, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("brr_valid_flushed", valid_id, 32'd0);
        checkOutput("brr_addr_target", imem_addr, 32'h200);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("brr_addr_next", imem_addr, 32'h204);
        checkOutput("brr_valid7", valid_id, 32'd0);
`ifdef IF_PERF_CNT_EN
        checkOutput("brr_perf_dropped", perf_dropped, 32'd2);
`endif
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("brr_valid8", valid_id, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("brr_valid9", valid_id, 32'd1);
        checkOutput("brr_pc9", pc_id, 32'h200);
        checkOutput("brr_pc4_9", pc_plus_four_id, 32'h204);

        $display("[TB] reset mid-stream");
        lat = 1;
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("mid_valid", valid_id, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("mid_reset_valid", valid_id, 32'd0);
        checkOutput("mid_reset_req", imem_req, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("mid_release_req", imem_req, 32'd1);
        checkOutput("mid_release_addr", imem_addr, RESET_PC);

        $display("[TB] randomized traffic");
        gnt_rand = 1'b1;
        rsp_rand = 1'b1;
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        pops_before = pops;
        for (int i = 0; i < 1000; i++) begin
            s = ($urandom_range(0, 99) < ((i < 500) ? 70 : 20));
            b = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 2))
                0: bpc = $urandom() & 32'hFFFF_FFFC;
                1: bpc = 32'hFFFF_FFF0;
                default: bpc = 32'h0000_1000;
            endcase
            applyStimulus(1'b0, s, b, bpc);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("random_progress", 32'(pops - pops_before >= 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
